// File: rtl/n_x_serdes_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : n_x_serdes_tx_pkg
// Purpose  : Shared defaults and types for the 7:1 fabric serial transmitter:
//            word width, forwarded-clock / training / idle words, training
//            length, underrun counter width and the link state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package n_x_serdes_tx_pkg;

    localparam int unsigned C_S             = 7;
    localparam logic [6:0]  C_CLK_PATTERN   = 7'b1100011;
    localparam logic [6:0]  C_TRAIN_PATTERN = 7'b0011101;
    localparam logic [6:0]  C_IDLE_WORD     = 7'b0000000;
    localparam int unsigned C_TRAIN_WORDS   = 64;
    localparam int unsigned C_UNDERRUN_W    = 16;

    typedef enum logic [0:0] {
        ST_TRAIN = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage : n_x_serdes_tx_pkg
`default_nettype wire

// File: rtl/n_x_serdes_7_to_1_fabric_tx_lane_shift.sv
`default_nettype none
// ============================================================================
// Module   : serdes_tx_lane_shift
// Purpose  : S-bit parallel-load / shift-left register for one serial lane.
//            The MSB is the serial output, so a loaded word leaves MSB-first.
// Ports    : clk, reset (async, active-high)
//            load       - load load_word this cycle, otherwise shift left
//            load_word  - next word for this lane
//            msb        - registered serial bit
// Revision : 1.0 - initial release
// ============================================================================
module serdes_tx_lane_shift
    import n_x_serdes_tx_pkg::*;
#(
    parameter int unsigned S = C_S
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [S-1:0] load_word,
    output logic         msb
);

    logic [S-1:0] r_shift;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
        end else if (load) begin
            r_shift <= load_word;
        end else begin
            r_shift <= {r_shift[S-2:0], 1'b0};
        end
    end

    assign msb = r_shift[S-1];

endmodule : serdes_tx_lane_shift
`default_nettype wire

// File: rtl/n_x_serdes_7_to_1_fabric_tx.sv
`default_nettype none
// ============================================================================
// Module   : n_x_serdes_7_to_1_fabric_tx
// Purpose  : 7:1 fabric serial link transmitter. Accepts D parallel S-bit
//            words per handshake and serialises them MSB-first, one bit per
//            clk, beside a forwarded-clock lane that frames each word. Sends
//            a training sequence after reset or on request, and an idle word
//            (counted as an underrun) when no data is offered.
// Ports    : clk, reset (async, active-high)
//            tx_data/tx_valid/tx_ready - word handshake, lane i at [i*S +: S]
//            train_en      - training request, sampled at word boundary
//            underrun_clr  - synchronous clear of underrun_cnt
//            ser_dat       - D serial data lanes (registered)
//            ser_clk       - forwarded-clock lane (registered)
//            word_start    - MSB of a word is on the serial outputs
//            in_train      - word on the serial outputs is a training word
//            underrun_cnt  - saturating idle-substitution count
// Revision : 1.0 - initial release
// ============================================================================
module n_x_serdes_7_to_1_fabric_tx
    import n_x_serdes_tx_pkg::*;
#(
    parameter int unsigned D             = 2,
    parameter int unsigned S             = C_S,
    parameter logic [S-1:0] CLK_PATTERN   = C_CLK_PATTERN,
    parameter logic [S-1:0] TRAIN_PATTERN = C_TRAIN_PATTERN,
    parameter logic [S-1:0] IDLE_WORD     = C_IDLE_WORD,
    parameter int unsigned TRAIN_WORDS   = C_TRAIN_WORDS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [D*S-1:0]          tx_data,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    input  logic                    train_en,
    input  logic                    underrun_clr,
    output logic [D-1:0]            ser_dat,
    output logic                    ser_clk,
    output logic                    word_start,
    output logic                    in_train,
    output logic [C_UNDERRUN_W-1:0] underrun_cnt
);

    localparam int unsigned CW = (S > 1) ? $clog2(S) : 1;
    localparam int unsigned TW = $clog2(TRAIN_WORDS + 1);
    localparam int unsigned UW = C_UNDERRUN_W;

    localparam logic [CW-1:0] C_CNT_LAST   = CW'(S - 1);
    localparam logic [CW-1:0] C_CNT_ONE    = CW'(1);
    localparam logic [TW-1:0] C_TRAIN_LAST = TW'(TRAIN_WORDS - 1);
    localparam logic [TW-1:0] C_TRAIN_ONE  = TW'(1);
    localparam logic [UW-1:0] C_UR_ONE     = UW'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CW-1:0] r_cnt;
    state_t        r_state;
    logic [TW-1:0] r_train_cnt;
    logic [UW-1:0] r_underrun_cnt;
    logic          r_word_start;
    logic          r_in_train;

    // ------------------------------------------------------------------
    // Next-state signals
    // ------------------------------------------------------------------
    logic           w_boundary;
    state_t         w_state_nxt;
    logic [TW-1:0]  w_train_cnt_nxt;
    logic [UW-1:0]  w_underrun_nxt;
    logic           w_underrun_inc;
    logic           w_in_train_nxt;
    logic [D*S-1:0] w_lane_words;
    logic [D:0]     w_msb;

    assign w_boundary = (r_cnt == C_CNT_LAST);

    // The handshake only opens on the boundary cycle, and a pending training
    // request closes it so that word is never consumed.
    assign tx_ready = (r_state == ST_RUN) & w_boundary & ~train_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt          <= '0;
            r_state        <= ST_TRAIN;
            r_train_cnt    <= '0;
            r_underrun_cnt <= '0;
            r_word_start   <= 1'b0;
            r_in_train     <= 1'b1;
        end else begin
            r_cnt          <= w_boundary ? '0 : (r_cnt + C_CNT_ONE);
            r_state        <= w_state_nxt;
            r_train_cnt    <= w_train_cnt_nxt;
            r_underrun_cnt <= w_underrun_nxt;
            r_word_start   <= w_boundary;
            r_in_train     <= w_in_train_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_train_cnt_nxt = r_train_cnt;
        w_in_train_nxt  = r_in_train;
        w_underrun_inc  = 1'b0;
        w_lane_words    = {D{IDLE_WORD}};

        if (w_boundary) begin
            case (r_state)
                ST_TRAIN: begin
                    w_lane_words   = {D{TRAIN_PATTERN}};
                    w_in_train_nxt = 1'b1;
                    if (train_en) begin
                        // Training length is counted from the last request.
                        w_train_cnt_nxt = '0;
                    end else if (r_train_cnt == C_TRAIN_LAST) begin
                        w_state_nxt     = ST_RUN;
                        w_train_cnt_nxt = '0;
                    end else begin
                        w_train_cnt_nxt = r_train_cnt + C_TRAIN_ONE;
                    end
                end
                ST_RUN: begin
                    if (train_en) begin
                        w_state_nxt     = ST_TRAIN;
                        w_train_cnt_nxt = '0;
                        w_lane_words    = {D{TRAIN_PATTERN}};
                        w_in_train_nxt  = 1'b1;
                    end else if (tx_valid) begin
                        w_lane_words   = tx_data;
                        w_in_train_nxt = 1'b0;
                    end else begin
                        w_lane_words   = {D{IDLE_WORD}};
                        w_in_train_nxt = 1'b0;
                        w_underrun_inc = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt     = ST_TRAIN;
                    w_train_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Clear has priority over a coincident increment.
    always_comb begin
        w_underrun_nxt = r_underrun_cnt;
        if (underrun_clr) begin
            w_underrun_nxt = '0;
        end else if (w_underrun_inc && (r_underrun_cnt != '1)) begin
            w_underrun_nxt = r_underrun_cnt + C_UR_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Lane shifters: D data lanes plus the forwarded-clock lane at index D
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi <= D; gi++) begin : g_lane
        logic [S-1:0] w_word;
        if (gi < D) begin : g_data
            assign w_word = w_lane_words[gi*S +: S];
        end else begin : g_clk
            assign w_word = CLK_PATTERN;
        end
        serdes_tx_lane_shift #(
            .S (S)
        ) u_shift (
            .clk       (clk),
            .reset     (reset),
            .load      (w_boundary),
            .load_word (w_word),
            .msb       (w_msb[gi])
        );
    end

    assign ser_dat      = w_msb[D-1:0];
    assign ser_clk      = w_msb[D];
    assign word_start   = r_word_start;
    assign in_train     = r_in_train;
    assign underrun_cnt = r_underrun_cnt;

endmodule : n_x_serdes_7_to_1_fabric_tx
`default_nettype wire

// File: tb/tb_n_x_serdes_7_to_1_fabric_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_n_x_serdes_7_to_1_fabric_tx
// Purpose  : Self-checking bench for the 7:1 fabric transmitter. A word-level
//            model predicts every serial bit, word_start, in_train,
//            underrun_cnt and tx_ready each cycle; literal checks pin the
//            training length, bit order and saturation behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_n_x_serdes_7_to_1_fabric_tx;

    localparam int D  = 2;
    localparam int S  = 7;
    localparam int TW = 64;
    localparam logic [6:0] CLKP   = 7'b1100011;
    localparam logic [6:0] TRAINP = 7'b0011101;
    localparam logic [6:0] IDLEW  = 7'b0000000;

    logic          clk          = 1'b0;
    logic          reset        = 1'b1;
    logic [D*S-1:0] tx_data     = '0;
    logic          tx_valid     = 1'b0;
    logic          train_en     = 1'b0;
    logic          underrun_clr = 1'b0;
    logic          tx_ready;
    logic [D-1:0]  ser_dat;
    logic          ser_clk;
    logic          word_start;
    logic          in_train;
    logic [15:0]   underrun_cnt;

    n_x_serdes_7_to_1_fabric_tx dut (
        .clk          (clk),
        .reset        (reset),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .train_en     (train_en),
        .underrun_clr (underrun_clr),
        .ser_dat      (ser_dat),
        .ser_clk      (ser_clk),
        .word_start   (word_start),
        .in_train     (in_train),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Word-level model: which word is on the wire and which bit of it.
    // ------------------------------------------------------------------
    int         m_n;        // clock edges since reset release
    bit         m_run;
    int         m_rem;      // training words still owed
    logic [6:0] m_word [D];
    logic [6:0] m_clkw;
    int         m_pos;
    bit         m_loaded;
    bit         m_ws;
    bit         m_intrain;
    int         m_under;

    always @(negedge clk) begin : p_compare
        logic [D-1:0] e_dat;
        logic         e_clk;
        bit           bnd;
        bit           inc;
        if (reset) begin
            chk("reset ser_dat", 32'(ser_dat), 0);
            chk("reset ser_clk", 32'(ser_clk), 0);
            chk("reset word_start", 32'(word_start), 0);
            chk("reset tx_ready", 32'(tx_ready), 0);
            chk("reset in_train", 32'(in_train), 1);
            chk("reset underrun_cnt", 32'(underrun_cnt), 0);
            m_n = 0; m_run = 0; m_rem = TW; m_loaded = 0; m_pos = 0;
            m_ws = 0; m_intrain = 1; m_under = 0;
        end else begin
            for (int i = 0; i < D; i++)
                e_dat[i] = m_loaded ? m_word[i][S-1-m_pos] : 1'b0;
            e_clk = m_loaded ? m_clkw[S-1-m_pos] : 1'b0;
            bnd   = ((m_n % S) == S - 1);
            chk("ser_dat", 32'(ser_dat), 32'(e_dat));
            chk("ser_clk", 32'(ser_clk), 32'(e_clk));
            chk("word_start", 32'(word_start), 32'(m_ws));
            chk("in_train", 32'(in_train), 32'(m_intrain));
            chk("underrun_cnt", 32'(underrun_cnt), 32'(m_under));
            chk("tx_ready", 32'(tx_ready), 32'(m_run && bnd && !train_en));

            // Predict the effect of the coming edge.
            inc = 0;
            if (bnd) begin
                if (!m_run) begin
                    for (int i = 0; i < D; i++) m_word[i] = TRAINP;
                    m_intrain = 1;
                    if (train_en) m_rem = TW;
                    else begin
                        m_rem--;
                        if (m_rem == 0) m_run = 1;
                    end
                end else if (train_en) begin
                    m_run = 0;
                    m_rem = TW;
                    for (int i = 0; i < D; i++) m_word[i] = TRAINP;
                    m_intrain = 1;
                end else if (tx_valid) begin
                    for (int i = 0; i < D; i++) m_word[i] = tx_data[i*S +: S];
                    m_intrain = 0;
                end else begin
                    for (int i = 0; i < D; i++) m_word[i] = IDLEW;
                    m_intrain = 0;
                    inc = 1;
                end
                m_clkw   = CLKP;
                m_pos    = 0;
                m_loaded = 1;
                m_ws     = 1;
            end else begin
                m_ws = 0;
                if (m_loaded) m_pos++;
            end
            if (underrun_clr) m_under = 0;
            else if (inc && m_under != 65535) m_under++;
            m_n++;
        end
    end

    // Called right after reset release: checks the training sequence
    // and the edge on which the handshake first opens.
    task automatic train_check(input string tag);
        int first = -1;
        for (int e = 0; e < 600 && first < 0; e++) begin
            @(negedge clk);
            if (e == 6) chk({tag, " no word_start before first word"}, 32'(word_start), 0);
            if (e == 7) begin
                chk({tag, " first word_start"}, 32'(word_start), 1);
                chk({tag, " first clk bit"}, 32'(ser_clk), 1);
                chk({tag, " first train bits"}, 32'(ser_dat), 0);
            end
            if (e == 9) begin
                chk({tag, " third train bits"}, 32'(ser_dat), 32'h3);
                chk({tag, " third clk bit"}, 32'(ser_clk), 0);
            end
            if (tx_ready) first = e;
        end
        chk({tag, " first tx_ready edge"}, 32'(first), 454);
        chk({tag, " in_train at end of training"}, 32'(in_train), 1);
        chk({tag, " no underruns during training"}, 32'(underrun_cnt), 0);
        @(posedge clk); #2;
    endtask

    task automatic wait_ready(input string tag);
        bit seen = 0;
        for (int k = 0; k < 1000 && !seen; k++) begin
            @(negedge clk);
            if (tx_ready) seen = 1;
        end
        chk({tag, " tx_ready seen"}, 32'(seen), 1);
        @(posedge clk); #2;
    endtask

    initial begin : p_stim
        int  u0;
        bit  seen;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // Training after reset, then idle words.
        train_check("boot");
        repeat (28) @(posedge clk);
        #1 chk("five idle underruns", 32'(underrun_cnt), 5);
        #1;

        // Fixed word: lane0 1010101, lane1 1010100.
        tx_data  = 14'h2A55;
        tx_valid = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("2A55 MSB", 32'(ser_dat), 32'h3);
        chk("2A55 word_start", 32'(word_start), 1);
        chk("2A55 in_train", 32'(in_train), 0);
        repeat (6) @(negedge clk);
        chk("2A55 LSB", 32'(ser_dat), 32'h1);
        chk("2A55 no underrun", 32'(underrun_cnt), 5);
        @(posedge clk); #2;

        // Random traffic, occasional clears and train pulses.
        for (int c = 0; c < 700; c++) begin
            tx_data      = D*S'($urandom);
            tx_valid     = ($urandom_range(0, 9) < 8);
            underrun_clr = ($urandom_range(0, 49) == 0);
            train_en     = ($urandom_range(0, 299) == 0);
            @(posedge clk); #2;
        end
        train_en = 1'b0; underrun_clr = 1'b0; tx_valid = 1'b1;

        // Exactly three missing words.
        wait_ready("pre-drop");
        u0 = int'(underrun_cnt);
        tx_valid = 1'b0;
        repeat (21) @(posedge clk);
        #2 chk("three dropped words", 32'(int'(underrun_cnt) - u0), 3);
        tx_valid = 1'b1;

        // Training request held across boundaries.
        train_en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tx_data = D*S'($urandom);
            @(posedge clk); #2;
        end
        train_en = 1'b0;
        for (int c = 0; c < TW*S + 40; c++) begin
            tx_data = D*S'($urandom);
            @(posedge clk); #2;
        end

        // Saturation and clear-over-increment.
        tx_valid = 1'b0;
        wait_ready("pre-saturate");
        #1;
        force dut.r_underrun_cnt = 16'hFFFD;
        m_under = 16'hFFFD;
        #1 release dut.r_underrun_cnt;
        repeat (35) @(posedge clk);
        #2 chk("underrun saturates", 32'(underrun_cnt), 32'hFFFF);
        underrun_clr = 1'b1;
        repeat (7) @(posedge clk);
        #1 chk("clear beats increment", 32'(underrun_cnt), 0);
        #1 underrun_clr = 1'b0;
        repeat (14) @(posedge clk);
        #2;

        // Asynchronous reset mid-word.
        tx_valid = 1'b1;
        tx_data  = 14'h3FFF;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (word_start) seen = 1;
        end
        chk("word_start before mid-word reset", 32'(seen), 1);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async rst ser_dat", 32'(ser_dat), 0);
        chk("async rst ser_clk", 32'(ser_clk), 0);
        chk("async rst word_start", 32'(word_start), 0);
        chk("async rst in_train", 32'(in_train), 1);
        chk("async rst underrun_cnt", 32'(underrun_cnt), 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        tx_valid = 1'b0;
        train_check("post-reset");
        repeat (30) @(posedge clk);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : p_watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_n_x_serdes_7_to_1_fabric_tx
`default_nettype wire
